fp_accum_ctrl: RTL and testbench

Multi-cycle accumulation sequencer that sums a packet of IEEE-754 single-precision values by driving an external start/done floating-point adder. It sits upstream of the adder as the requester side of the adder's handshake. It buffers incoming operands in a small FIFO, chains partial sums through the adder one operation at a time, and returns one result per packet over a valid/ready output.

---
 rtl/fp_accum_ctrl_if.sv | 42 ++++
 rtl/fp_accum_ctrl.sv | 179 +++++++++++++++++
 tb/tb_fp_accum_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_accum_ctrl_if.sv
// rtl/fp_accum_ctrl_if.sv - handshake bundle for fp_accum_ctrl: operand input, adder request, result output, status
interface fp_accum_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;

    logic        add_start;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [31:0] add_sum;
    logic        add_done;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    logic        busy;
    logic        err_timeout;

    // Accumulator side: consumes operands, requests adds, produces results.
    modport slave (
        input  in_valid, in_data, in_last,
        input  add_sum, add_done,
        input  out_ready,
        output in_ready,
        output add_start, add_a, add_b,
        output out_valid, out_data,
        output busy, err_timeout
    );

    // Environment side: operand producer, adder and result consumer.
    modport master (
        output in_valid, in_data, in_last,
        output add_sum, add_done,
        output out_ready,
        input  in_ready,
        input  add_start, add_a, add_b,
        input  out_valid, out_data,
        input  busy, err_timeout
    );
endinterface

// File: rtl/fp_accum_ctrl.sv
// rtl/fp_accum_ctrl.sv - packet accumulation sequencer driving an external start/done FP32 adder
module fp_accum_ctrl #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           reset,
    fp_accum_ctrl_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [AW:0]    CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [TW-1:0]  T_LAST   = TW'(TIMEOUT - 1);
    localparam logic [31:0]    QNAN     = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_NEXT,
        S_ISSUE,
        S_WAIT,
        S_DRAIN,
        S_OUT
    } state_t;

    state_t state, state_nx;

    // Operand FIFO: each entry carries the element and its end-of-packet flag.
    logic [31:0]   fifo_data [DEPTH];
    logic          fifo_last [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic [31:0]   head_data;
    logic          head_last;

    // Accumulation state.
    logic [31:0]   acc,   acc_nx;
    logic [31:0]   opb,   opb_nx;
    logic          lastf, lastf_nx;
    logic [TW-1:0] timer, timer_nx;
    logic          err,   err_nx;
    logic          add_start_c;
    logic          out_valid_c;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_FULL);
    assign push       = bus.in_valid && !fifo_full;
    assign head_data  = fifo_data[rd_ptr];
    assign head_last  = fifo_last[rd_ptr];

    // FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= bus.in_data;
            fifo_last[wr_ptr] <= bus.in_last;
        end
    end

    // State and accumulation registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            acc   <= '0;
            opb   <= '0;
            lastf <= 1'b0;
            timer <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            opb   <= opb_nx;
            lastf <= lastf_nx;
            timer <= timer_nx;
            err   <= err_nx;
        end
    end

    // Sequencer: load first element, chain one add per further element, publish the sum.
    always_comb begin
        state_nx    = state;
        acc_nx      = acc;
        opb_nx      = opb;
        lastf_nx    = lastf;
        timer_nx    = timer;
        err_nx      = err;
        pop         = 1'b0;
        add_start_c = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    acc_nx   = head_data;
                    state_nx = head_last ? S_OUT : S_NEXT;
                end
            end
            S_NEXT: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    opb_nx   = head_data;
                    lastf_nx = head_last;
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                add_start_c = 1'b1;
                timer_nx    = '0;
                state_nx    = S_WAIT;
            end
            S_WAIT: begin
                timer_nx = timer + 1'b1;
                // A done still high from the previous add is ignored in the first WAIT cycle.
                if (bus.add_done && (timer != '0)) begin
                    acc_nx   = bus.add_sum;
                    state_nx = lastf ? S_OUT : S_NEXT;
                end else if (timer == T_LAST) begin
                    err_nx   = 1'b1;
                    acc_nx   = QNAN;
                    state_nx = lastf ? S_OUT : S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Discard the rest of an aborted packet up to and including its last element.
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head_last) begin
                        state_nx = S_OUT;
                    end
                end
            end
            S_OUT: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // acc and opb only change on WAIT exit or in NEXT, so the adder operands stay stable across the add.
    assign bus.in_ready    = !fifo_full;
    assign bus.add_start   = add_start_c;
    assign bus.add_a       = acc;
    assign bus.add_b       = opb;
    assign bus.out_valid   = out_valid_c;
    assign bus.out_data    = acc;
    assign bus.busy        = (state != S_IDLE) || !fifo_empty;
    assign bus.err_timeout = err;

endmodule

// File: tb/tb_fp_accum_ctrl.sv
// tb/tb_fp_accum_ctrl.sv - directed self-checking bench for fp_accum_ctrl with a behavioural adder model
module tb_fp_accum_ctrl;

    localparam int MODE_NORMAL = 0;
    localparam int MODE_HANG   = 1;
    localparam int MODE_STALE  = 2;
    localparam int LAT         = 5;

    logic clk = 1'b0;
    logic reset;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    fp_accum_ctrl_if bus();

    fp_accum_ctrl #(.DEPTH(4), .TIMEOUT(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Adder model state.
    int          mode = MODE_NORMAL;
    int          cnt;
    logic        pend;
    logic [31:0] pa, pb;
    logic [31:0] prev_a, prev_b, last_a, last_b;
    int          n_starts = 0;

    function automatic logic [31:0] sum_lut(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (a == 32'h40400000 && b == 32'h40400000) return 32'h40C00000;
        if (a == 32'h40000000 && b == 32'h40000000) return 32'h40800000;
        return 32'hDEADBEEF;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            bus.add_done <= 1'b0;
            bus.add_sum  <= '0;
            pend         <= 1'b0;
            cnt          <= 0;
        end else if (bus.add_start) begin
            n_starts <= n_starts + 1;
            prev_a   <= last_a;
            prev_b   <= last_b;
            last_a   <= bus.add_a;
            last_b   <= bus.add_b;
            pa       <= bus.add_a;
            pb       <= bus.add_b;
            pend     <= 1'b1;
            cnt      <= 1;
            if (mode != MODE_STALE) bus.add_done <= 1'b0;
        end else if (pend) begin
            cnt <= cnt + 1;
            if (cnt == LAT && mode != MODE_HANG) begin
                bus.add_done <= 1'b1;
                bus.add_sum  <= sum_lut(pa, pb);
                pend         <= 1'b0;
            end else begin
                bus.add_done <= 1'b0;
            end
        end
    end

    task automatic push(input logic [31:0] d, input logic l);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            total_cnt++;
            $display("FAIL push_timeout: in_ready=%b want 1 for data %h", bus.in_ready, d);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output logic ok, output logic [31:0] d);
        int n = 0;
        while (!bus.out_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        ok = bus.out_valid;
        d  = bus.out_data;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic wait_start(output logic ok);
        int n = 0;
        while (!bus.add_start && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = bus.add_start;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        total_cnt++;
        if ({bus.in_ready, bus.add_start, bus.out_valid, bus.busy, bus.err_timeout} !== 5'b10000)
            $display("FAIL reset_flags: rdy/start/ovalid/busy/err=%b want 10000",
                     {bus.in_ready, bus.add_start, bus.out_valid, bus.busy, bus.err_timeout});
        else pass_cnt++;
        total_cnt++;
        if (bus.add_a !== 32'h0) $display("FAIL reset_add_a: got %h want 00000000", bus.add_a);
        else pass_cnt++;
        total_cnt++;
        if (bus.add_b !== 32'h0) $display("FAIL reset_add_b: got %h want 00000000", bus.add_b);
        else pass_cnt++;
        total_cnt++;
        if (bus.out_data !== 32'h0) $display("FAIL reset_out_data: got %h want 00000000", bus.out_data);
        else pass_cnt++;
    endtask

    task automatic test_single();
        int base = n_starts;
        push(32'h40400000, 1'b1);
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL single_t1_valid: got %b want 0", bus.out_valid);
        else pass_cnt++;
        total_cnt++;
        if (bus.busy !== 1'b1) $display("FAIL single_busy: got %b want 1", bus.busy);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bus.out_valid !== 1'b1) $display("FAIL single_t2_valid: got %b want 1", bus.out_valid);
        else pass_cnt++;
        total_cnt++;
        if (bus.out_data !== 32'h40400000) $display("FAIL single_data: got %h want 40400000", bus.out_data);
        else pass_cnt++;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        total_cnt++;
        if (n_starts !== base) $display("FAIL single_no_start: got %0d starts want 0", n_starts - base);
        else pass_cnt++;
    endtask

    task automatic test_sum3();
        int base = n_starts;
        logic ok;
        logic [31:0] d;
        mode = MODE_NORMAL;
        push(32'h3F800000, 1'b0);
        push(32'h40000000, 1'b0);
        push(32'h40400000, 1'b1);
        wait_out(ok, d);
        total_cnt++;
        if (!ok || d !== 32'h40C00000) $display("FAIL sum3_data: got %h valid %b want 40C00000", d, ok);
        else pass_cnt++;
        total_cnt++;
        if (n_starts - base !== 2) $display("FAIL sum3_starts: got %0d want 2", n_starts - base);
        else pass_cnt++;
        total_cnt++;
        if ({prev_a, prev_b} !== {32'h3F800000, 32'h40000000})
            $display("FAIL sum3_op1: got %h,%h want 3F800000,40000000", prev_a, prev_b);
        else pass_cnt++;
        total_cnt++;
        if ({last_a, last_b} !== {32'h40400000, 32'h40400000})
            $display("FAIL sum3_op2: got %h,%h want 40400000,40400000", last_a, last_b);
        else pass_cnt++;
        total_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL sum3_idle_busy: got %b want 0", bus.busy);
        else pass_cnt++;
    endtask

    task automatic test_stale_done();
        logic ok;
        logic [31:0] d;
        mode = MODE_STALE;
        push(32'h3F800000, 1'b0);
        push(32'h40000000, 1'b1);
        wait_out(ok, d);
        total_cnt++;
        if (!ok || d !== 32'h40400000) $display("FAIL stale_done_sum: got %h valid %b want 40400000", d, ok);
        else pass_cnt++;
        mode = MODE_NORMAL;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_v [6] = '{32'h11111111, 32'h22222222, 32'h33333333,
                                   32'h44444444, 32'h55555555, 32'h66666666};
        int n = 0;
        bus.out_ready = 1'b0;
        push(exp_v[0], 1'b1);
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 1; i < 5; i++) push(exp_v[i], 1'b1);
        total_cnt++;
        if (bus.in_ready !== 1'b0) $display("FAIL bp_full: in_ready=%b want 0", bus.in_ready);
        else pass_cnt++;
        bus.in_valid = 1'b1;
        bus.in_data  = exp_v[5];
        bus.in_last  = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (bus.in_ready !== 1'b0) $display("FAIL bp_hold_ready: in_ready=%b want 0", bus.in_ready);
        else pass_cnt++;
        total_cnt++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== exp_v[0])
            $display("FAIL bp_hold_out: valid %b data %h want 1 %h", bus.out_valid, bus.out_data, exp_v[0]);
        else pass_cnt++;
        fork
            push(exp_v[5], 1'b1);
            begin
                logic ok;
                logic [31:0] d;
                for (int i = 0; i < 6; i++) begin
                    wait_out(ok, d);
                    total_cnt++;
                    if (!ok || d !== exp_v[i])
                        $display("FAIL bp_order[%0d]: got %h valid %b want %h", i, d, ok, exp_v[i]);
                    else pass_cnt++;
                end
            end
        join
    endtask

    task automatic test_timeout();
        logic ok;
        logic [31:0] d;
        int n = 0;
        mode = MODE_HANG;
        push(32'h3F800000, 1'b0);
        push(32'h40000000, 1'b0);
        push(32'h40400000, 1'b1);
        wait_start(ok);
        total_cnt++;
        if (!ok) $display("FAIL to_start: add_start=%b want 1", ok);
        else pass_cnt++;
        while (!bus.err_timeout && n < 100) begin
            @(negedge clk);
            n++;
        end
        total_cnt++;
        if (n !== 65) $display("FAIL to_latency: err after %0d cycles want 65", n);
        else pass_cnt++;
        wait_out(ok, d);
        total_cnt++;
        if (!ok || d !== 32'h7FC00000) $display("FAIL to_nan: got %h valid %b want 7FC00000", d, ok);
        else pass_cnt++;
        total_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL to_drained: busy=%b want 0", bus.busy);
        else pass_cnt++;
        mode = MODE_NORMAL;
        push(32'h40000000, 1'b0);
        push(32'h40000000, 1'b1);
        wait_out(ok, d);
        total_cnt++;
        if (!ok || d !== 32'h40800000) $display("FAIL to_next_pkt: got %h valid %b want 40800000", d, ok);
        else pass_cnt++;
        total_cnt++;
        if (bus.err_timeout !== 1'b1) $display("FAIL to_sticky: err=%b want 1", bus.err_timeout);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic ok;
        logic [31:0] d;
        mode = MODE_HANG;
        push(32'h3F800000, 1'b0);
        push(32'h40000000, 1'b1);
        wait_start(ok);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({bus.in_ready, bus.add_start, bus.out_valid, bus.busy, bus.err_timeout} !== 5'b10000)
            $display("FAIL rmid_flags: rdy/start/ovalid/busy/err=%b want 10000",
                     {bus.in_ready, bus.add_start, bus.out_valid, bus.busy, bus.err_timeout});
        else pass_cnt++;
        total_cnt++;
        if ({bus.add_a, bus.add_b, bus.out_data} !== 96'h0)
            $display("FAIL rmid_data: a %h b %h out %h want all 0", bus.add_a, bus.add_b, bus.out_data);
        else pass_cnt++;
        reset = 1'b0;
        mode  = MODE_NORMAL;
        @(negedge clk);
        push(32'h40000000, 1'b0);
        push(32'h40000000, 1'b1);
        wait_out(ok, d);
        total_cnt++;
        if (!ok || d !== 32'h40800000) $display("FAIL rmid_next_pkt: got %h valid %b want 40800000", d, ok);
        else pass_cnt++;
        total_cnt++;
        if (bus.err_timeout !== 1'b0) $display("FAIL rmid_err: err=%b want 0", bus.err_timeout);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_sum3();
        test_stale_done();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
